// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_BYTES        = 32'h0000_0004;

  typedef enum logic [0:0] {
    IF_BOOT  = 1'b0,
    IF_FETCH = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO: holds fetched {pc, instr} pairs; a synchronous clear drops everything.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CNT_FULL);
  assign count     = count_r;
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head      = empty ? fetch_entry_t'({(XLEN + ILEN){1'b0}}) : mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= fetch_entry_t'({(XLEN + ILEN){1'b0}});
      end
    end else if (clear) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: issues word fetches, buffers responses, and drops
// responses still in flight when EX redirects the PC.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            instr_req,
  output logic [XLEN-1:0] instr_addr,
  input  logic            instr_gnt,
  input  logic            instr_rvalid,
  input  logic [ILEN-1:0] instr_rdata,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_if,
  output logic [ILEN-1:0] instruction,
  output logic            instruction_value,
  output logic            is_compress_intr,
  input  logic            id_stage_ready
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   CAP     = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  if_state_e       state_r;
  if_state_e       state_s;
  logic [XLEN-1:0] fetch_addr_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [XLEN-1:0] target_s;
  logic [CW-1:0]   out_cnt_r;
  logic [CW-1:0]   out_cnt_s;
  logic [CW-1:0]   discard_cnt_r;
  logic [CW-1:0]   discard_cnt_s;
  logic [CW-1:0]   fifo_cnt_s;
  logic [CW:0]     inflight_s;
  logic            req_s;
  logic            fire_s;
  logic            rsp_take_s;
  logic            rsp_drop_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  fetch_entry_t    push_data_s;
  fetch_entry_t    head_s;

  assign target_s    = word_align(branch_target);
  assign inflight_s  = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_s};
  assign fire_s      = req_s & instr_gnt;
  assign rsp_take_s  = instr_rvalid & (discard_cnt_r == {CW{1'b0}});
  assign rsp_drop_s  = instr_rvalid & (discard_cnt_r != {CW{1'b0}});
  assign push_s      = rsp_take_s & ~branch_valid & (~fifo_full_s | pop_s);
  assign push_data_s = '{pc: rsp_pc_r, instr: instr_rdata};

  assign instruction_value = ~fifo_empty_s & ~branch_valid;
  assign pop_s             = instruction_value & id_stage_ready;
  assign pc_if             = head_s.pc;
  assign instruction       = head_s.instr;
  assign is_compress_intr  = 1'b0;
  assign instr_req         = req_s;
  assign instr_addr        = fetch_addr_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IF_BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: a single idle cycle after reset, then fetch forever.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IF_BOOT:  state_s = IF_FETCH;
      IF_FETCH: state_s = IF_FETCH;
      default:  state_s = IF_BOOT;
    endcase
  end

  // FSM outputs: the cap counts buffered entries too, so the FIFO can never overflow.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      IF_BOOT:  req_s = 1'b0;
      IF_FETCH: req_s = (inflight_s < CAP) & ~branch_valid;
      default:  req_s = 1'b0;
    endcase
  end

  // Requests granted but not yet answered.
  always_comb begin
    out_cnt_s = out_cnt_r;
    case ({fire_s, instr_rvalid})
      2'b10:   out_cnt_s = out_cnt_r + CNT_ONE;
      2'b01:   out_cnt_s = out_cnt_r - CNT_ONE;
      default: out_cnt_s = out_cnt_r;
    endcase
  end

  // On redirect every response still owed (stale discards included) must be dropped.
  always_comb begin
    discard_cnt_s = discard_cnt_r;
    if (branch_valid) begin
      discard_cnt_s = out_cnt_s;
    end else if (rsp_drop_s) begin
      discard_cnt_s = discard_cnt_r - CNT_ONE;
    end else begin
      discard_cnt_s = discard_cnt_r;
    end
  end

  // Fetch/response address tracking and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr_r  <= BOOT_ADDR;
      rsp_pc_r      <= BOOT_ADDR;
      out_cnt_r     <= {CW{1'b0}};
      discard_cnt_r <= {CW{1'b0}};
    end else begin
      out_cnt_r     <= out_cnt_s;
      discard_cnt_r <= discard_cnt_s;
      if (branch_valid) begin
        fetch_addr_r <= target_s;
        rsp_pc_r     <= target_s;
      end else begin
        if (fire_s) begin
          fetch_addr_r <= fetch_addr_r + WORD_BYTES;
        end
        if (rsp_take_s) begin
          rsp_pc_r <= rsp_pc_r + WORD_BYTES;
        end
      end
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (branch_valid),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_cnt_s)
  );

endmodule
